calc_sequencer: RTL and testbench

- Instruction sequencer directly upstream of the calculation stage; generates every control input that stage consumes.
- Accepts 8-bit instruction words plus per-stack operand bits over a valid/ready handshake.
- Expands each instruction into two clock phases: the E-stack update phase (cycle=0), then the T-stack update phase (cycle=1).
- Tracks logical stack depth and flags overflow/underflow before a bad instruction is issued.

---
 rtl/calc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: expands 8-bit instruction words into an E-phase / T-phase
// pair of stack controls for the downstream calculation stage, tracking the
// logical stack depth and refusing instructions that would over/underflow it.
module calc_sequencer #(
  parameter int unsigned DEPTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [7:0]                   instr_data,
  input  logic                         val_e,
  input  logic                         val_t,
  output logic                         cycle,
  output logic [3:0]                   lut,
  output logic [1:0]                   op,
  output logic                         do_pop,
  output logic                         val,
  output logic                         en_push_force,
  output logic                         en_pop,
  output logic                         en_push,
  output logic                         en_stack_wr,
  output logic [1:0]                   mux_sta,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PH_E,
    S_PH_T,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    K_LOAD   = 2'b00,
    K_REDUCE = 2'b01,
    K_ACCUM  = 2'b10,
    K_END    = 2'b11
  } kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    lut_q, lut_d;
  logic          ve_q, ve_d;
  logic          vt_q, vt_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0]    err_q, err_d;

  logic          xfer;
  logic          phase;
  logic [DW-1:0] depth_cmt;
  logic [DW-1:0] depth_chk;
  kind_t         kind_in;

  assign kind_in     = kind_t'(instr_data[7:6]);
  assign instr_ready = (state_q == S_FETCH) || (state_q == S_PH_T);
  assign xfer        = instr_valid && instr_ready;
  assign phase       = (state_q == S_PH_E) || (state_q == S_PH_T);

  // Depth after the in-flight instruction commits; a word accepted during
  // PH_T is checked against this value so back-to-back issue stays legal.
  always_comb begin
    depth_cmt = depth_q;
    case (kind_q)
      K_LOAD:   depth_cmt = depth_q + 1'b1;
      K_REDUCE: depth_cmt = depth_q - 1'b1;
      default:  depth_cmt = depth_q;
    endcase
    depth_chk = (state_q == S_PH_T) ? depth_cmt : depth_q;
  end

  // Next-state, depth bookkeeping and instruction latch.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    op_d    = op_q;
    lut_d   = lut_q;
    ve_d    = ve_q;
    vt_d    = vt_q;
    depth_d = depth_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      S_PH_E:  state_d = S_PH_T;
      S_PH_T: begin
        depth_d = depth_cmt;
        state_d = S_FETCH;
      end
      S_DONE, S_ERROR: begin
        if (clear) begin
          state_d = S_IDLE;
          depth_d = '0;
          err_d   = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Transfers only occur in FETCH/PH_T, so this overrides those arms.
    if (xfer) begin
      kind_d = kind_in;
      op_d   = instr_data[5:4];
      lut_d  = instr_data[3:0];
      ve_d   = val_e;
      vt_d   = val_t;
      case (kind_in)
        K_LOAD: begin
          if (depth_chk == DW'(DEPTH)) begin
            state_d = S_ERROR;
            err_d   = 2'b01;
          end else begin
            state_d = S_PH_E;
          end
        end
        K_REDUCE: begin
          if (depth_chk < DW'(2)) begin
            state_d = S_ERROR;
            err_d   = 2'b10;
          end else begin
            state_d = S_PH_E;
          end
        end
        K_END:   state_d = S_DONE;
        default: state_d = S_PH_E;
      endcase
    end
  end

  // State and latched-instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_LOAD;
      op_q    <= '0;
      lut_q   <= '0;
      ve_q    <= 1'b0;
      vt_q    <= 1'b0;
      depth_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      op_q    <= op_d;
      lut_q   <= lut_d;
      ve_q    <= ve_d;
      vt_q    <= vt_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack controls decoded from the latched kind, live only in the phases.
  always_comb begin
    en_push_force = 1'b0;
    en_pop        = 1'b0;
    en_push       = 1'b0;
    en_stack_wr   = 1'b0;
    do_pop        = 1'b0;
    mux_sta       = 2'b00;
    if (phase) begin
      case (kind_q)
        K_LOAD: begin
          en_push_force = 1'b1;
          en_stack_wr   = 1'b1;
          mux_sta       = 2'b00;
        end
        K_REDUCE: begin
          en_pop      = 1'b1;
          do_pop      = 1'b1;
          en_stack_wr = 1'b1;
          mux_sta     = 2'b10;
        end
        K_ACCUM: begin
          en_stack_wr = 1'b1;
          mux_sta     = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign cycle    = (state_q == S_PH_T);
  assign val      = (state_q == S_PH_E) ? ve_q : ((state_q == S_PH_T) ? vt_q : 1'b0);
  assign op       = op_q;
  assign lut      = lut_q;
  assign depth    = depth_q;
  assign busy     = phase || (state_q == S_FETCH);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);
  assign err_code = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          start;
  logic          clear;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr_data;
  logic          val_e;
  logic          val_t;
  logic          cycle;
  logic [3:0]    lut;
  logic [1:0]    op;
  logic          do_pop;
  logic          val;
  logic          en_push_force;
  logic          en_pop;
  logic          en_push;
  logic          en_stack_wr;
  logic [1:0]    mux_sta;
  logic [DW-1:0] depth;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  int unsigned n_vec;
  int unsigned n_err;

  calc_sequencer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear         (clear),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .val_e         (val_e),
    .val_t         (val_t),
    .cycle         (cycle),
    .lut           (lut),
    .op            (op),
    .do_pop        (do_pop),
    .val           (val),
    .en_push_force (en_push_force),
    .en_pop        (en_pop),
    .en_push       (en_push),
    .en_stack_wr   (en_stack_wr),
    .mux_sta       (mux_sta),
    .depth         (depth),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All stack controls in one word: {epf, en_pop, en_push, wr, do_pop, mux[1:0]}.
  function automatic int unsigned ctl();
    return {en_push_force, en_pop, en_push, en_stack_wr, do_pop, mux_sta};
  endfunction

  task automatic reset_start();
    reset = 1'b0;
    start = 1'b0; clear = 1'b0; instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH: issue one word, let both phases run, end back in FETCH.
  task automatic issue(input logic [7:0] d, input logic ve, input logic vt);
    instr_valid = 1'b1; instr_data = d; val_e = ve; val_t = vt;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
  endtask

  localparam logic [7:0] W_LOAD = 8'h00;
  localparam logic [7:0] W_RED  = 8'b01_01_0110;
  localparam logic [7:0] W_ACC  = 8'b10_11_1010;
  localparam logic [7:0] W_END  = 8'b11_00_0000;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    instr_valid = 1'b0; instr_data = '0; val_e = 1'b0; val_t = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_error", error, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err",   err_code, 0);
    chk("rst_ready", instr_ready, 0);
    chk("rst_ctl",   ctl(), 0);
    chk("rst_cycle", cycle, 0);

    // Single LOAD with val_e=1, val_t=0
    reset = 1'b1;
    tick();
    chk("idle_ready", instr_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_busy",  busy, 1);
    chk("fetch_ready", instr_ready, 1);
    instr_valid = 1'b1; instr_data = W_LOAD; val_e = 1'b1; val_t = 1'b0;
    tick();
    instr_valid = 1'b0;
    chk("ld_e_cycle", cycle, 0);
    chk("ld_e_val",   val, 1);
    chk("ld_e_ctl",   ctl(), 7'b1001000);
    chk("ld_e_ready", instr_ready, 0);
    chk("ld_e_depth", depth, 0);
    tick();
    chk("ld_t_cycle", cycle, 1);
    chk("ld_t_val",   val, 0);
    chk("ld_t_ctl",   ctl(), 7'b1001000);
    chk("ld_t_ready", instr_ready, 1);
    tick();
    chk("ld_depth",   depth, 1);
    chk("ld_fetch_ctl", ctl(), 0);
    chk("ld_fetch_busy", busy, 1);

    // ACCUM keeps depth, writes with mux 11
    instr_valid = 1'b1; instr_data = W_ACC; val_e = 1'b0; val_t = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("acc_e_ctl", ctl(), 7'b0001011);
    chk("acc_e_val", val, 0);
    chk("acc_op",    op, 3);
    chk("acc_lut",   lut, 4'hA);
    tick();
    chk("acc_t_val", val, 1);
    chk("acc_t_cycle", cycle, 1);
    tick();
    chk("acc_depth", depth, 1);

    // Back-to-back LOAD, LOAD, REDUCE from depth 0
    reset_start();
    instr_valid = 1'b1; instr_data = W_LOAD; val_e = 1'b0; val_t = 1'b1;
    tick();
    chk("b2b_c0", cycle, 0);
    chk("b2b_v0", val, 0);
    tick();
    chk("b2b_c1", cycle, 1);
    chk("b2b_v1", val, 1);
    tick();
    chk("b2b_c2", cycle, 0);
    chk("b2b_busy2", busy, 1);
    chk("b2b_ctl2", ctl(), 7'b1001000);
    chk("b2b_depth2", depth, 1);
    instr_data = W_RED; val_e = 1'b1; val_t = 1'b0;
    tick();
    chk("b2b_c3", cycle, 1);
    chk("b2b_ctl3", ctl(), 7'b1001000);
    tick();
    instr_valid = 1'b0;
    chk("b2b_c4",    cycle, 0);
    chk("b2b_ctl4",  ctl(), 7'b0101110);
    chk("b2b_op4",   op, 1);
    chk("b2b_lut4",  lut, 4'b0110);
    chk("b2b_v4",    val, 1);
    chk("b2b_depth4", depth, 2);
    tick();
    chk("b2b_c5",   cycle, 1);
    chk("b2b_ctl5", ctl(), 7'b0101110);
    chk("b2b_v5",   val, 0);
    tick();
    chk("b2b_depth", depth, 1);
    chk("b2b_idle_ctl", ctl(), 0);

    // Overflow on the seventh LOAD
    reset_start();
    for (int i = 0; i < 6; i++) issue(W_LOAD, 1'b0, 1'b0);
    chk("ovf_depth6", depth, 6);
    instr_valid = 1'b1; instr_data = W_LOAD;
    tick();
    instr_valid = 1'b0;
    chk("ovf_error", error, 1);
    chk("ovf_code",  err_code, 2'b01);
    chk("ovf_depth", depth, 6);
    chk("ovf_ctl",   ctl(), 0);
    chk("ovf_busy",  busy, 0);
    tick();
    chk("ovf_hold",  error, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_start_ign", error, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_error", error, 0);
    chk("clr_depth", depth, 0);
    chk("clr_code",  err_code, 0);
    chk("clr_busy",  busy, 0);

    // Underflow: REDUCE at depth 1
    start = 1'b1;
    tick();
    start = 1'b0;
    issue(W_LOAD, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_data = W_RED;
    tick();
    instr_valid = 1'b0;
    chk("udf_error", error, 1);
    chk("udf_code",  err_code, 2'b10);
    chk("udf_depth", depth, 1);
    chk("udf_pop",   en_pop, 0);
    tick();
    chk("udf_pop2",  en_pop, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // LOAD then END
    start = 1'b1;
    tick();
    start = 1'b0;
    issue(W_LOAD, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_data = W_END;
    tick();
    chk("end_done",  done, 1);
    chk("end_busy",  busy, 0);
    chk("end_ready", instr_ready, 0);
    chk("end_ctl",   ctl(), 0);
    instr_data = W_LOAD;
    tick(); tick();
    chk("end_hold",  done, 1);
    chk("end_depth", depth, 1);
    chk("end_ctl2",  ctl(), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("end_clr_ready", instr_ready, 0);
    chk("end_clr_done",  done, 0);
    tick();
    chk("end_idle_ctl", ctl(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    instr_valid = 1'b0;
    chk("end_restart", ctl(), 7'b1001000);
    tick(); tick();

    // Asynchronous reset mid-instruction at depth 2
    reset_start();
    issue(W_LOAD, 1'b0, 1'b0);
    issue(W_LOAD, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_data = W_LOAD; val_e = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ar_pre_ctl", ctl(), 7'b1001000);
    chk("ar_pre_val", val, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ctl",   ctl(), 0);
    chk("ar_val",   val, 0);
    chk("ar_busy",  busy, 0);
    chk("ar_depth", depth, 0);
    tick();
    reset = 1'b1;
    instr_valid = 1'b1;
    tick(); tick();
    instr_valid = 1'b0;
    chk("ar_noresume_busy",  busy, 0);
    chk("ar_noresume_ready", instr_ready, 0);
    chk("ar_noresume_depth", depth, 0);
    chk("ar_noresume_ctl",   ctl(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
